// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector (1..MAX_LEN bits), Mealy/Moore and overlap selectable.
// Optional saturating match counter built when SEQ_DET_COUNT_EN is defined.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               din,
    input  logic               din_valid,
    input  logic               MACHINE,
    input  logic               OVERLAP,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_FILL     = 2'd1,
        ST_ARMED    = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_fill;
    logic               r_out;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_fill_inc;
    logic               w_match;
    logic               w_hit;

    // ARMED means the incoming bit can complete a full-length window.
    function automatic state_t state_for(input logic [LEN_W-1:0] len,
                                         input logic [LEN_W-1:0] fill);
        if (len == '0)
            return ST_DISABLED;
        else if (fill >= len - LEN_W'(1))
            return ST_ARMED;
        else
            return ST_FILL;
    endfunction

    always_comb begin
        w_len_clamp = (cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;
        w_fill_inc  = (r_fill == MAX_LEN_W) ? r_fill : r_fill + LEN_W'(1);
        w_window    = {r_hist, din};
        w_mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_match = (((w_window ^ r_pat) & w_mask) == '0);
        // A load in the same cycle drops the incoming bit entirely.
        w_hit   = din_valid & ~cfg_load & (r_state == ST_ARMED) & w_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DISABLED;
            r_pat   <= '0;
            r_hist  <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
        end else if (cfg_load) begin
            r_pat   <= cfg_pattern;
            r_len   <= w_len_clamp;
            r_hist  <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
            r_state <= state_for(w_len_clamp, '0);
        end else begin
            r_out <= w_hit;
            if (din_valid) begin
                r_hist <= w_window[MAX_LEN-2:0];
                if (w_hit && !OVERLAP) begin
                    r_fill  <= '0;
                    r_state <= state_for(r_len, '0);
                end else begin
                    r_fill  <= w_fill_inc;
                    r_state <= state_for(r_len, w_fill_inc);
                end
            end
        end
    end

    assign out = MACHINE ? w_hit : r_out;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (cfg_load)
            r_cnt <= '0;
        else if (w_hit && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the received bit stream.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
`ifdef SEQ_DET_COUNT_EN
    localparam int CNT_W   = 2;
`else
    localparam int CNT_W   = 16;
`endif

    logic               clk;
    logic               rst_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               din;
    logic               din_valid;
    logic               MACHINE;
    logic               OVERLAP;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;

    int checks   = 0;
    int failures = 0;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .din(din), .din_valid(din_valid), .MACHINE(MACHINE),
        .OVERLAP(OVERLAP), .out(out), .match_cnt(match_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bits received since the last load/reset/non-overlap hit.
    logic       m_bits[$];
    int         m_len;
    logic [7:0] m_pat;
    logic       m_prev;
    int         m_cnt;
    int         cnt_max;

    always @(negedge clk) begin : model
        logic hit;
        logic b;
        logic exp_out;
        cnt_max = (1 << CNT_W) - 1;
        if (!rst_n) begin
            m_bits.delete();
            m_len  = 0;
            m_pat  = '0;
            m_prev = 1'b0;
            m_cnt  = 0;
            chk("rst_out", {31'd0, out}, 32'd0);
            chk("rst_cnt", 32'(match_cnt), 32'd0);
        end else begin
            hit = 1'b0;
            if (!cfg_load && din_valid && m_len > 0 && (m_bits.size() + 1) >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    b = (i == 0) ? din : m_bits[m_bits.size() - i];
                    if (b != m_pat[i]) hit = 1'b0;
                end
            end
            exp_out = MACHINE ? hit : m_prev;
            chk("model_out", {31'd0, out}, {31'd0, exp_out});
            chk("model_cnt", 32'(match_cnt), 32'(m_cnt));
            if (cfg_load) begin
                m_len  = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_pat  = cfg_pattern;
                m_bits.delete();
                m_prev = 1'b0;
                m_cnt  = 0;
            end else begin
                if (din_valid) begin
                    if (hit && !OVERLAP) begin
                        m_bits.delete();
                    end else begin
                        m_bits.push_back(din);
                        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                    end
                end
                m_prev = hit;
`ifdef SEQ_DET_COUNT_EN
                if (hit && m_cnt < cnt_max) m_cnt++;
`endif
            end
        end
    end

    // Driver tasks
    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len,
                            input logic d, input logic v);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; din = d; din_valid = v;
        @(negedge clk); #1;
        chk("load_out", {31'd0, out}, 32'd0);
    endtask

    task automatic bit_step(input logic d, input logic v, input logic e, input string nm);
        @(posedge clk); #1;
        cfg_load = 1'b0; din = d; din_valid = v;
        @(negedge clk); #1;
        chk(nm, {31'd0, out}, {31'd0, e});
    endtask

    task automatic run_seq(input logic [15:0] bits, input logic [15:0] vld,
                           input logic [15:0] exp, input int n, input string nm);
        for (int i = n - 1; i >= 0; i--) bit_step(bits[i], vld[i], exp[i], nm);
    endtask

    int t6_exp[5];

    initial begin
`ifdef SEQ_DET_COUNT_EN
        t6_exp = '{1, 2, 3, 3, 3};
`else
        t6_exp = '{0, 0, 0, 0, 0};
`endif
        rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        din = 1'b0; din_valid = 1'b0; MACHINE = 1'b1; OVERLAP = 1'b0;
        #12;
        chk("reset_out", {31'd0, out}, 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        #10 rst_n = 1'b1;

        // 001, Mealy, non-overlap
        load_cfg(8'b001, 4'd3, 1'b0, 1'b0);
        run_seq(16'b001001, 16'b111111, 16'b001001, 6, "t1_mealy_001");

        // 101 with and without overlap
        OVERLAP = 1'b1;
        load_cfg(8'b101, 4'd3, 1'b0, 1'b0);
        run_seq(16'b10101, 16'b11111, 16'b00101, 5, "t2_overlap");
        OVERLAP = 1'b0;
        load_cfg(8'b101, 4'd3, 1'b0, 1'b0);
        run_seq(16'b10101, 16'b11111, 16'b00100, 5, "t2_nonoverlap");

        // Moore 0110 with valid gaps: out one cycle after the completing bit
        MACHINE = 1'b0;
        load_cfg(8'b0110, 4'd4, 1'b0, 1'b0);
        run_seq(16'b001010000, 16'b101010100, 16'b000000010, 9, "t3_moore");

        // load mid-match drops the concurrent bit and the history
        MACHINE = 1'b1;
        load_cfg(8'b001, 4'd3, 1'b0, 1'b0);
        run_seq(16'b00, 16'b11, 16'b00, 2, "t4_pre");
        load_cfg(8'b001, 4'd3, 1'b1, 1'b1);
        run_seq(16'b1001, 16'b1111, 16'b0001, 4, "t4_post");

        // disabled, then over-long length clamps to MAX_LEN
        load_cfg(8'($urandom), 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++)
            bit_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "t5_disabled");
        load_cfg(8'hA5, 4'd15, 1'b0, 1'b0);
        run_seq(16'hA5, 16'hFF, 16'h01, 8, "t5_len15");

        // length 1, continuous hits, counter saturation, async reset mid-stream
        load_cfg(8'h01, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_step(1'b1, 1'b1, 1'b1, "t6_out");
            if (i > 0) chk("t6_cnt", 32'(match_cnt), 32'(t6_exp[i-1]));
        end
        @(posedge clk); #1;
        din = 1'b1; din_valid = 1'b1;
        chk("t6_cnt_last", 32'(match_cnt), 32'(t6_exp[4]));
        chk("t6_out_pre_rst", {31'd0, out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out", {31'd0, out}, 32'd0);
        chk("t6_rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 39) == 0) begin
                cfg_load    = 1'b1;
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 4));
            end else begin
                cfg_load = 1'b0;
            end
            din       = 1'($urandom_range(0, 1));
            din_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) MACHINE = ~MACHINE;
            if ($urandom_range(0, 19) == 0) OVERLAP = ~OVERLAP;
        end
        @(posedge clk); #1;
        cfg_load = 1'b0; din_valid = 1'b0;
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
